sample_fifo: RTL and testbench

//  Frame FIFO between the ADC capture stage (upstream) and the SPI output module (downstream).

---
 rtl/sample_fifo_pkg.sv | 10 +
 rtl/sample_ram.sv | 19 +
 rtl/sample_fifo.sv | 76 +++++++
 tb/tb_sample_fifo.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sample_fifo_pkg.sv
// sample_fifo_pkg: shared ADC frame parameters for the capture-to-SPI path
package sample_fifo_pkg;
  localparam int CLK_FREQ = 36_000_000;
  localparam int SAMPLE_RATE = 48_000;
  localparam int NUM_CHANNELS = 8;
  localparam int BITS_PER_SAMPLE = 16;
  localparam int SAMPLE_WIDTH = NUM_CHANNELS * BITS_PER_SAMPLE;
  localparam int DEPTH_LOG2 = 8;
  localparam int RESYNC_LEVEL = SAMPLE_RATE / 1000;
endpackage

// File: rtl/sample_ram.sv
// sample_ram: simple dual-port frame store, one write port and a registered read port
module sample_ram #(
  parameter int W = 128,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sample_fifo.sv
// sample_fifo: frame FIFO from ADC capture to SPI output with show-ahead head,
// burst resync credit and flush-on-overflow
module sample_fifo #(
  parameter int NUM_CHANNELS = sample_fifo_pkg::NUM_CHANNELS,
  parameter int BITS_PER_SAMPLE = sample_fifo_pkg::BITS_PER_SAMPLE,
  parameter int DEPTH_LOG2 = sample_fifo_pkg::DEPTH_LOG2,
  parameter int RESYNC_LEVEL = sample_fifo_pkg::RESYNC_LEVEL,
  localparam int SW = NUM_CHANNELS * BITS_PER_SAMPLE,
  localparam int CW = DEPTH_LOG2 + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] wr_data,
  input  logic          wr_valid,
  output logic [SW-1:0] rd_data,
  input  logic          rd_ready,
  output logic          resync,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);
  localparam logic [CW-1:0] CAP = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [CW-1:0] LVL = CW'(RESYNC_LEVEL);
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] burst_left, ram_cnt, count_nxt, burst_nxt;
  logic [SW-1:0] head, ram_q;
  logic head_valid, head_valid_nxt, land, pop, flush, wr_ok, fetch, arm;
  sample_ram #(.W(SW), .AW(DEPTH_LOG2)) u_ram (
    .clk(clk), .we(wr_valid), .waddr(wr_ptr), .wdata(wr_data),
    .re(fetch), .raddr(rd_ptr), .rdata(ram_q)
  );
  assign pop = rd_ready & head_valid;
  assign flush = wr_valid & full & ~pop;
  assign wr_ok = wr_valid & (~full | pop);
  // head_valid also covers the cycle where the fetched frame is still on the RAM output
  assign ram_cnt = count - CW'(head_valid);
  assign fetch = ~head_valid & (ram_cnt != '0);
  assign rd_data = land ? ram_q : head;
  assign arm = (burst_left == '0) & (count >= LVL);
  always_comb begin
    count_nxt = flush ? CW'(1) : count + CW'(wr_ok) - CW'(pop);
    head_valid_nxt = flush ? 1'b0 : fetch ? 1'b1 : pop ? 1'b0 : head_valid;
    burst_nxt = flush ? '0 : arm ? LVL : (pop && burst_left != '0) ? burst_left - CW'(1) : burst_left;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      burst_left <= '0;
      head <= '0;
      head_valid <= 1'b0;
      land <= 1'b0;
      empty <= 1'b1;
      full <= 1'b0;
      resync <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_valid) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (flush) rd_ptr <= wr_ptr;
      else if (fetch) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      if (land) head <= ram_q;
      land <= fetch & ~flush;
      head_valid <= head_valid_nxt;
      empty <= ~head_valid_nxt;
      count <= count_nxt;
      full <= count_nxt == CAP;
      burst_left <= burst_nxt;
      resync <= arm & ~flush;
      overflow <= flush;
      underflow <= rd_ready & ~head_valid;
    end
endmodule

// File: tb/tb_sample_fifo.sv
// tb_sample_fifo: scoreboard bench for sample_fifo ordering, resync credit, flush and underflow
module tb_sample_fifo;
  localparam int SW = 128;
  logic clk = 1'b0, rst = 1'b1;
  logic [SW-1:0] wr_data = '0, rd_data, last = '0, x, y, z, e;
  logic wr_valid = 1'b0, rd_ready = 1'b0;
  logic resync, empty, full, overflow, underflow;
  logic [8:0] count;
  int total = 0, bad = 0, n_res = 0, n_ovf = 0, n_udf = 0, r0, o0, u0;
  logic [SW-1:0] q[$];
  always #5 clk = ~clk;
  sample_fifo dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .rd_data(rd_data),
    .rd_ready(rd_ready), .resync(resync), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );
  always @(negedge clk) begin
    if (resync) n_res++;
    if (overflow) n_ovf++;
    if (underflow) n_udf++;
  end
  task automatic chk(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic logic [SW-1:0] frame(input int i);
    logic [SW-1:0] r;
    for (int c = 0; c < 8; c++) r[c*16 +: 16] = {4'(c), 12'(i)};
    return r;
  endfunction
  task automatic wr(input logic [SW-1:0] d);
    wr_data = d;
    wr_valid = 1'b1;
    cyc(1);
    wr_valid = 1'b0;
    q.push_back(d);
  endtask
  task automatic pop();
    logic [SW-1:0] ex;
    for (int i = 0; i < 8 && empty; i++) cyc(1);
    chk("head_ready", empty, 0);
    ex = (q.size() != 0) ? q.pop_front() : '0;
    chk("pop_data", rd_data, ex);
    last = ex;
    rd_ready = 1'b1;
    cyc(1);
    rd_ready = 1'b0;
  endtask
  task automatic popn(input int n);
    for (int i = 0; i < n; i++) begin
      pop();
      cyc(2);
    end
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    cyc(3);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_resync", resync, 0);
    rst = 1'b0;
    cyc(1);
    // reset with frames queued
    for (int i = 1; i <= 10; i++) wr(frame(100 + i));
    cyc(3);
    chk("t1_count", count, 10);
    chk("t1_empty", empty, 0);
    rst = 1'b1;
    cyc(1);
    chk("t1_rst_count", count, 0);
    chk("t1_rst_empty", empty, 1);
    chk("t1_rst_rd_data", rd_data, 0);
    chk("t1_rst_resync", resync, 0);
    rst = 1'b0;
    q.delete();
    cyc(1);
    // slow fill to the resync level, then drain in order
    r0 = n_res;
    for (int i = 1; i <= 48; i++) begin
      wr(frame(i));
      if (i < 48) cyc(749);
    end
    chk("t2_count", count, 48);
    chk("t2_no_early", resync, 0);
    chk("t2_pre_pulses", n_res - r0, 0);
    cyc(1);
    chk("t2_resync", resync, 1);
    cyc(1);
    chk("t2_resync_end", resync, 0);
    popn(48);
    cyc(3);
    chk("t2_empty", empty, 1);
    chk("t2_count_end", count, 0);
    chk("t2_pulses", n_res - r0, 1);
    // credit blocks a second pulse until 48 pops
    r0 = n_res;
    for (int i = 1; i <= 100; i++) wr(frame(200 + i));
    cyc(2);
    chk("t3_count", count, 100);
    chk("t3_one_pulse", n_res - r0, 1);
    popn(47);
    chk("t3_hold", n_res - r0, 1);
    pop();
    chk("t3_rs_pre", resync, 0);
    cyc(1);
    chk("t3_rs", resync, 1);
    chk("t3_count52", count, 52);
    // overflow flush
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    q.delete();
    r0 = n_res;
    o0 = n_ovf;
    for (int i = 1; i <= 256; i++) wr(frame(1000 + i));
    cyc(1);
    chk("t4_count256", count, 256);
    chk("t4_full", full, 1);
    chk("t4_no_ovf", n_ovf - o0, 0);
    x = {$urandom, $urandom, $urandom, $urandom};
    wr_data = x;
    wr_valid = 1'b1;
    cyc(1);
    wr_valid = 1'b0;
    chk("t4_ovf", overflow, 1);
    chk("t4_count1", count, 1);
    chk("t4_full_clr", full, 0);
    q.delete();
    q.push_back(x);
    cyc(1);
    chk("t4_ovf_end", overflow, 0);
    chk("t4_rd_x", rd_data, x);
    chk("t4_not_empty", empty, 0);
    chk("t4_ovf_pulses", n_ovf - o0, 1);
    for (int i = 1; i <= 47; i++) wr(frame(2000 + i));
    cyc(2);
    chk("t4_rearm", n_res - r0, 2);
    // write and pop together while full
    for (int i = 1; i <= 208; i++) wr(frame(2100 + i));
    cyc(2);
    chk("t5_count", count, 256);
    chk("t5_full", full, 1);
    y = {$urandom, $urandom, $urandom, $urandom};
    e = q.pop_front();
    chk("t5_head", rd_data, e);
    wr_data = y;
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    cyc(1);
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    q.push_back(y);
    chk("t5_no_ovf", overflow, 0);
    chk("t5_count", count, 256);
    chk("t5_still_full", full, 1);
    cyc(2);
    chk("t5_adv", rd_data, q[0]);
    popn(256);
    cyc(3);
    chk("t5_empty", empty, 1);
    chk("t5_count0", count, 0);
    chk("t5_ovf_total", n_ovf - o0, 1);
    // underflow, then single-frame latency
    u0 = n_udf;
    rd_ready = 1'b1;
    cyc(1);
    rd_ready = 1'b0;
    chk("t6_udf", underflow, 1);
    chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_rd_hold", rd_data, last);
    cyc(1);
    chk("t6_udf_end", underflow, 0);
    chk("t6_udf_pulses", n_udf - u0, 1);
    z = {$urandom, $urandom, $urandom, $urandom};
    wr(z);
    chk("t6_n1_empty", empty, 1);
    chk("t6_n1_count", count, 1);
    cyc(1);
    chk("t6_n2_empty", empty, 0);
    chk("t6_n2_data", rd_data, z);
    pop();
    cyc(2);
    chk("t6_final_empty", empty, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
